// File: rtl/axim_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-port arbiter and the loader controllers
// that reuse its state encoding and pointer sizing.
package axim_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AR    = 2'd1,
    RDATA = 2'd2
  } arb_state_e;

  localparam int C_REQ_NUM_DEF          = 32'sd3;
  localparam int C_M_AXI_LEN_WIDTH_DEF  = 32'sd32;
  localparam int C_M_AXI_ADDR_WIDTH_DEF = 32'sd32;
  localparam int C_M_AXI_DATA_WIDTH_DEF = 32'sd128;

  // Ceiling log2, never below one bit so a single requester still has a pointer.
  function automatic int log2_ceil(input int value);
    int width;
    width = 32'sd1;
    while ((32'sd1 << width) < value) begin
      width = width + 32'sd1;
    end
    return width;
  endfunction

endpackage

// File: rtl/axim_rd_arbiter_if.sv
// Loader-side and AXI-master-side signal bundle of the read-port arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface axim_rd_arbiter_if
  import axim_rd_arbiter_pkg::*;
#(
  parameter int C_REQ_NUM          = C_REQ_NUM_DEF,
  parameter int C_M_AXI_LEN_WIDTH  = C_M_AXI_LEN_WIDTH_DEF,
  parameter int C_M_AXI_ADDR_WIDTH = C_M_AXI_ADDR_WIDTH_DEF,
  parameter int C_M_AXI_DATA_WIDTH = C_M_AXI_DATA_WIDTH_DEF
);

  logic [C_REQ_NUM-1:0]                    I_arvalid;
  logic [C_REQ_NUM*C_M_AXI_ADDR_WIDTH-1:0] I_araddr;
  logic [C_REQ_NUM*C_M_AXI_LEN_WIDTH-1:0]  I_arlen;
  logic [C_REQ_NUM-1:0]                    O_arready;
  logic [C_REQ_NUM-1:0]                    I_rready;
  logic [C_REQ_NUM-1:0]                    O_rvalid;
  logic [C_M_AXI_DATA_WIDTH-1:0]           O_rdata;
  logic [C_REQ_NUM-1:0]                    O_gnt;
  logic                                    O_busy;
  logic                                    O_maxi_arvalid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]           O_maxi_araddr;
  logic [C_M_AXI_LEN_WIDTH-1:0]            O_maxi_arlen;
  logic                                    I_maxi_arready;
  logic                                    O_maxi_rready;
  logic                                    I_maxi_rvalid;
  logic [C_M_AXI_DATA_WIDTH-1:0]           I_maxi_rdata;

  modport slave (
    input  I_arvalid,
    input  I_araddr,
    input  I_arlen,
    input  I_rready,
    input  I_maxi_arready,
    input  I_maxi_rvalid,
    input  I_maxi_rdata,
    output O_arready,
    output O_rvalid,
    output O_rdata,
    output O_gnt,
    output O_busy,
    output O_maxi_arvalid,
    output O_maxi_araddr,
    output O_maxi_arlen,
    output O_maxi_rready
  );

  modport master (
    output I_arvalid,
    output I_araddr,
    output I_arlen,
    output I_rready,
    output I_maxi_arready,
    output I_maxi_rvalid,
    output I_maxi_rdata,
    input  O_arready,
    input  O_rvalid,
    input  O_rdata,
    input  O_gnt,
    input  O_busy,
    input  O_maxi_arvalid,
    input  O_maxi_araddr,
    input  O_maxi_arlen,
    input  O_maxi_rready
  );

endinterface

// File: rtl/axim_rd_arbiter_rr_pick.sv
// Combinational round-robin select: the first active request at or above the
// pointer, wrapping past the highest index.
module axim_rd_arbiter_rr_pick
  import axim_rd_arbiter_pkg::*;
#(
  parameter int C_REQ_NUM = C_REQ_NUM_DEF,
  parameter int C_PTR_W   = log2_ceil(C_REQ_NUM)
) (
  input  logic [C_REQ_NUM-1:0] req,
  input  logic [C_PTR_W-1:0]   ptr,
  output logic [C_REQ_NUM-1:0] win_onehot,
  output logic [C_PTR_W-1:0]   win_idx,
  output logic                 any_req
);

  int   best_dist_s;
  int   dist_s;
  logic found_s;

  // Rank each requester by its rotational distance from the pointer; closest wins.
  always_comb begin
    best_dist_s = C_REQ_NUM;
    dist_s      = 32'sd0;
    found_s     = 1'b0;
    win_idx     = '0;
    win_onehot  = '0;
    for (int i = 0; i < C_REQ_NUM; i++) begin
      if (i >= int'(ptr)) begin
        dist_s = i - int'(ptr);
      end else begin
        dist_s = i + C_REQ_NUM - int'(ptr);
      end
      if (req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        win_idx     = C_PTR_W'(i);
        found_s     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    for (int i = 0; i < C_REQ_NUM; i++) begin
      win_onehot[i] = found_s && (win_idx == C_PTR_W'(i));
    end
    any_req = |req;
  end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Shares one AXI read master among the bias/weight/image loaders: one burst at a
// time, round-robin grant, held until the last R beat of the burst.
module axim_rd_arbiter
  import axim_rd_arbiter_pkg::*;
#(
  parameter int C_REQ_NUM          = C_REQ_NUM_DEF,
  parameter int C_M_AXI_LEN_WIDTH  = C_M_AXI_LEN_WIDTH_DEF,
  parameter int C_M_AXI_ADDR_WIDTH = C_M_AXI_ADDR_WIDTH_DEF,
  parameter int C_M_AXI_DATA_WIDTH = C_M_AXI_DATA_WIDTH_DEF
) (
  input logic              I_clk,
  input logic              I_rst_n,
  axim_rd_arbiter_if.slave bus
);

  localparam int C_PTR_W = log2_ceil(C_REQ_NUM);

  arb_state_e                    state_r;
  arb_state_e                    state_s;
  logic [C_PTR_W-1:0]            ptr_r;
  logic [C_PTR_W-1:0]            ptr_s;
  logic [C_REQ_NUM-1:0]          gnt_r;
  logic [C_REQ_NUM-1:0]          gnt_s;
  logic                          arvalid_r;
  logic                          arvalid_s;
  logic                          busy_r;
  logic                          busy_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_r;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_s;
  logic [C_M_AXI_LEN_WIDTH-1:0]  len_r;
  logic [C_M_AXI_LEN_WIDTH-1:0]  len_s;
  logic [C_M_AXI_LEN_WIDTH-1:0]  cnt_r;
  logic [C_M_AXI_LEN_WIDTH-1:0]  cnt_s;

  logic [C_REQ_NUM-1:0]          win_onehot_s;
  logic [C_PTR_W-1:0]            win_idx_s;
  logic [C_PTR_W-1:0]            ptr_next_s;
  logic                          any_req_s;
  logic [C_M_AXI_ADDR_WIDTH-1:0] sel_addr_s;
  logic [C_M_AXI_LEN_WIDTH-1:0]  sel_len_s;
  logic                          in_idle_s;
  logic                          in_rdata_s;
  logic                          rready_sel_s;
  logic                          beat_s;

  axim_rd_arbiter_rr_pick #(
    .C_REQ_NUM (C_REQ_NUM),
    .C_PTR_W   (C_PTR_W)
  ) u_rr_pick (
    .req        (bus.I_arvalid),
    .ptr        (ptr_r),
    .win_onehot (win_onehot_s),
    .win_idx    (win_idx_s),
    .any_req    (any_req_s)
  );

  // Extract the winner's address and length from the packed request fields.
  always_comb begin
    sel_addr_s = '0;
    sel_len_s  = '0;
    for (int i = 0; i < C_REQ_NUM; i++) begin
      sel_addr_s = sel_addr_s
                 | (bus.I_araddr[i*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH]
                    & {C_M_AXI_ADDR_WIDTH{win_onehot_s[i]}});
      sel_len_s  = sel_len_s
                 | (bus.I_arlen[i*C_M_AXI_LEN_WIDTH +: C_M_AXI_LEN_WIDTH]
                    & {C_M_AXI_LEN_WIDTH{win_onehot_s[i]}});
    end
  end

  assign ptr_next_s   = (win_idx_s == C_PTR_W'(C_REQ_NUM - 1)) ? '0 : win_idx_s + C_PTR_W'(1);
  assign in_idle_s    = (state_r == IDLE);
  assign in_rdata_s   = (state_r == RDATA);
  assign rready_sel_s = |(bus.I_rready & gnt_r);
  assign beat_s       = in_rdata_s && bus.I_maxi_rvalid && rready_sel_s;

  // Next state and next burst context; all holds are the defaults.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    gnt_s     = gnt_r;
    arvalid_s = arvalid_r;
    addr_s    = addr_r;
    len_s     = len_r;
    cnt_s     = cnt_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          addr_s    = sel_addr_s;
          len_s     = sel_len_s;
          gnt_s     = win_onehot_s;
          ptr_s     = ptr_next_s;
          arvalid_s = 1'b1;
          state_s   = AR;
        end else begin
          state_s   = IDLE;
        end
      end
      AR: begin
        if (arvalid_r && bus.I_maxi_arready) begin
          arvalid_s = 1'b0;
          cnt_s     = '0;
          state_s   = RDATA;
        end else begin
          state_s   = AR;
        end
      end
      RDATA: begin
        // Equality against the latched length, so arlen of all-ones never wraps early.
        if (beat_s && (cnt_r == len_r)) begin
          gnt_s   = '0;
          cnt_s   = '0;
          state_s = IDLE;
        end else if (beat_s) begin
          cnt_s   = cnt_r + C_M_AXI_LEN_WIDTH'(1);
        end else begin
          state_s = RDATA;
        end
      end
      default: begin
        gnt_s     = '0;
        arvalid_s = 1'b0;
        cnt_s     = '0;
        state_s   = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Burst context: pointer, grant, latched AR fields and beat counter.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ptr_r     <= '0;
      gnt_r     <= '0;
      arvalid_r <= 1'b0;
      busy_r    <= 1'b0;
      addr_r    <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
    end else begin
      ptr_r     <= ptr_s;
      gnt_r     <= gnt_s;
      arvalid_r <= arvalid_s;
      busy_r    <= busy_s;
      addr_r    <= addr_s;
      len_r     <= len_s;
      cnt_r     <= cnt_s;
    end
  end

  // The loader handshake is combinational, but must stay silent while reset is held.
  assign bus.O_arready      = (in_idle_s && I_rst_n) ? win_onehot_s : '0;
  assign bus.O_rvalid       = (in_rdata_s && bus.I_maxi_rvalid) ? gnt_r : '0;
  assign bus.O_maxi_rready  = in_rdata_s && rready_sel_s;
  assign bus.O_rdata        = bus.I_maxi_rdata;
  assign bus.O_gnt          = gnt_r;
  assign bus.O_busy         = busy_r;
  assign bus.O_maxi_arvalid = arvalid_r;
  assign bus.O_maxi_araddr  = addr_r;
  assign bus.O_maxi_arlen   = len_r;

endmodule

// File: tb/tb_axim_rd_arbiter.sv
// Scoreboard bench for axim_rd_arbiter: requests are queued as they are issued and a
// negedge monitor checks grants, AR fields and R routing against a transaction model.
`timescale 1ns/1ps
module tb_axim_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int DW = 128;
  localparam int P_IDLE = 0;
  localparam int P_AR   = 1;
  localparam int P_RD   = 2;

  typedef struct {
    int          who;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  req_t exp_q[$];

  // Transaction model state, owned by the monitor.
  int          m_phase = P_IDLE;
  int          m_ptr = 0;
  longint      m_left = 0;
  longint      m_done = 0;
  req_t        m_cur;
  logic [N-1:0] m_gnt = '0;
  int          m_w;
  int          m_found;
  logic [N-1:0] m_exp_rdy;
  logic        m_rr;

  axim_rd_arbiter_if #(
    .C_REQ_NUM (N), .C_M_AXI_LEN_WIDTH (LW),
    .C_M_AXI_ADDR_WIDTH (AW), .C_M_AXI_DATA_WIDTH (DW)
  ) bus ();

  axim_rd_arbiter #(
    .C_REQ_NUM (N), .C_M_AXI_LEN_WIDTH (LW),
    .C_M_AXI_ADDR_WIDTH (AW), .C_M_AXI_DATA_WIDTH (DW)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin from the model pointer, computed with plain modulo arithmetic.
  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (((int'(req) >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  // Monitor: compares every DUT output against the transaction model each cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", DW'(bus.O_gnt), '0);
      chk("rst_busy", DW'(bus.O_busy), '0);
      chk("rst_arvalid", DW'(bus.O_maxi_arvalid), '0);
      chk("rst_araddr", DW'(bus.O_maxi_araddr), '0);
      chk("rst_arlen", DW'(bus.O_maxi_arlen), '0);
      chk("rst_arready", DW'(bus.O_arready), '0);
      chk("rst_rvalid", DW'(bus.O_rvalid), '0);
      chk("rst_rready", DW'(bus.O_maxi_rready), '0);
      m_phase = P_IDLE; m_ptr = 0; m_left = 0; m_done = 0; m_gnt = '0;
    end else begin
      chk("rdata_pass", bus.O_rdata, bus.I_maxi_rdata);
      case (m_phase)
        P_IDLE: begin
          chk("idle_busy", DW'(bus.O_busy), '0);
          chk("idle_gnt", DW'(bus.O_gnt), '0);
          chk("idle_arvalid", DW'(bus.O_maxi_arvalid), '0);
          chk("idle_rvalid", DW'(bus.O_rvalid), '0);
          chk("idle_rready", DW'(bus.O_maxi_rready), '0);
          m_w = rr_winner(bus.I_arvalid, m_ptr);
          m_exp_rdy = (m_w < 0) ? '0 : N'(1 << m_w);
          chk("idle_arready", DW'(bus.O_arready), DW'(m_exp_rdy));
          if (m_w >= 0) begin
            m_found = -1;
            for (int k = 0; k < exp_q.size(); k++) begin
              if (m_found < 0 && exp_q[k].who == m_w) m_found = k;
            end
            if (m_found < 0) begin
              chk("exp_q_entry", '0, DW'(1));
            end else begin
              m_cur = exp_q[m_found];
              exp_q.delete(m_found);
            end
            m_gnt = m_exp_rdy;
            m_ptr = (m_w + 1) % N;
            m_phase = P_AR;
          end
        end
        P_AR: begin
          chk("ar_busy", DW'(bus.O_busy), DW'(1));
          chk("ar_gnt", DW'(bus.O_gnt), DW'(m_gnt));
          chk("ar_arvalid", DW'(bus.O_maxi_arvalid), DW'(1));
          chk("ar_araddr", DW'(bus.O_maxi_araddr), DW'(m_cur.addr));
          chk("ar_arlen", DW'(bus.O_maxi_arlen), DW'(m_cur.len));
          chk("ar_arready", DW'(bus.O_arready), '0);
          chk("ar_rvalid", DW'(bus.O_rvalid), '0);
          chk("ar_rready", DW'(bus.O_maxi_rready), '0);
          if (bus.I_maxi_arready) begin
            m_phase = P_RD;
            m_left = longint'(m_cur.len) + 64'sd1;
            m_done = 0;
          end
        end
        default: begin
          m_rr = |(bus.I_rready & m_gnt);
          chk("rd_busy", DW'(bus.O_busy), DW'(1));
          chk("rd_gnt", DW'(bus.O_gnt), DW'(m_gnt));
          chk("rd_arvalid", DW'(bus.O_maxi_arvalid), '0);
          chk("rd_arready", DW'(bus.O_arready), '0);
          chk("rd_rready", DW'(bus.O_maxi_rready), DW'(m_rr));
          chk("rd_rvalid", DW'(bus.O_rvalid), bus.I_maxi_rvalid ? DW'(m_gnt) : '0);
          if (bus.I_maxi_rvalid && m_rr) begin
            m_done++;
            m_left--;
            if (m_left == 0) m_phase = P_IDLE;
          end
        end
      endcase
    end
  end

  task automatic post_req(input int who, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_t r;
    r.who = who; r.addr = addr; r.len = len;
    bus.I_arvalid[who] = 1'b1;
    bus.I_araddr[who*AW +: AW] = addr;
    bus.I_arlen[who*LW +: LW] = len;
    exp_q.push_back(r);
  endtask

  // One clock: handshaken loaders drop their request just after the edge.
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = bus.O_arready & bus.I_arvalid;
    @(posedge clk);
    #1;
    bus.I_arvalid = bus.I_arvalid & ~hs;
  endtask

  task automatic rand_fill(input int pct, input int len_max);
    for (int i = 0; i < N; i++) begin
      if (!bus.I_arvalid[i] && ($urandom_range(0, 99) < pct))
        post_req(i, $urandom(), LW'($urandom_range(0, len_max)));
    end
  endtask

  task automatic rand_axi();
    bus.I_maxi_arready = 1'($urandom_range(0, 1));
    bus.I_maxi_rvalid  = ($urandom_range(0, 3) != 0);
    bus.I_maxi_rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 0; i < N; i++) bus.I_rready[i] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset_now();
    rst_n = 1'b0;
    #1;
    chk("rstnow_gnt", DW'(bus.O_gnt), '0);
    chk("rstnow_busy", DW'(bus.O_busy), '0);
    chk("rstnow_arvalid", DW'(bus.O_maxi_arvalid), '0);
    chk("rstnow_rvalid", DW'(bus.O_rvalid), '0);
    chk("rstnow_rready", DW'(bus.O_maxi_rready), '0);
    chk("rstnow_arready", DW'(bus.O_arready), '0);
    bus.I_arvalid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    bus.I_arvalid = '0; bus.I_araddr = '0; bus.I_arlen = '0; bus.I_rready = '0;
    bus.I_maxi_arready = 1'b0; bus.I_maxi_rvalid = 1'b0; bus.I_maxi_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request, AR accepted after two cycles, four beats, stray rvalid throughout.
    bus.I_rready = '1; bus.I_maxi_rvalid = 1'b1;
    post_req(0, 32'h0000_1000, 32'd3);
    for (int c = 0; c < 12; c++) begin
      cycle();
      bus.I_maxi_arready = (c >= 1);
      bus.I_maxi_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    // All three continuously requesting single-beat bursts.
    for (int i = 0; i < N; i++) post_req(i, $urandom(), 32'd0);
    for (int c = 0; c < 30; c++) begin
      cycle();
      for (int i = 0; i < N; i++) if (!bus.I_arvalid[i]) post_req(i, $urandom(), 32'd0);
    end
    for (int c = 0; c < 8; c++) cycle();
    bus.I_arvalid = '0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) cycle();

    // Loader 1 backpressure: rready toggles every cycle on a two-beat burst.
    bus.I_rready = '0;
    post_req(1, 32'h0000_5000, 32'd1);
    for (int c = 0; c < 12; c++) begin
      cycle();
      bus.I_rready[1] = ~bus.I_rready[1];
    end
    bus.I_rready = '1;

    // Stray rvalid with 0xDEAD in IDLE and AR.
    bus.I_maxi_rdata = 128'hDEAD; bus.I_maxi_arready = 1'b0;
    for (int c = 0; c < 4; c++) cycle();
    post_req(2, 32'h0000_7000, 32'd0);
    for (int c = 0; c < 4; c++) cycle();
    bus.I_maxi_arready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    // Reset during beat 3 of an 8-beat burst, then loader 2 alone.
    post_req(0, 32'h0000_A000, 32'd7);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      cycle();
      if (m_phase == P_RD && m_done == 2) ok = 1'b1;
    end
    if (!ok) chk("wait_beat2", '0, DW'(1));
    do_reset_now();
    post_req(2, 32'h0000_2000, 32'd1);
    for (int c = 0; c < 8; c++) cycle();

    // Maximum arlen: field passes through untouched and 16 beats do not end the burst.
    post_req(0, 32'h0000_3000, 32'hFFFF_FFFF);
    for (int c = 0; c < 20; c++) cycle();
    chk("maxlen_arlen", DW'(bus.O_maxi_arlen), DW'(32'hFFFF_FFFF));
    chk("maxlen_busy", DW'(bus.O_busy), DW'(1));
    do_reset_now();
    post_req(1, 32'h0000_4000, 32'd0);
    post_req(2, 32'h0000_4100, 32'd0);
    for (int c = 0; c < 10; c++) cycle();

    // Random traffic on both sides.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      rand_fill(30, 4);
      rand_axi();
    end

    // Drain outstanding bursts with a bounded budget.
    bus.I_maxi_arready = 1'b1; bus.I_maxi_rvalid = 1'b1; bus.I_rready = '1;
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      cycle();
      if (m_phase == P_IDLE && bus.I_arvalid == '0 && exp_q.size() == 0) ok = 1'b1;
    end
    if (!ok) chk("drain", '0, DW'(1));
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axim_rd_arbiter.md
Name: axim_rd_arbiter

Overview:
- Shares one AXI master read port (AR and R channels) among C_REQ_NUM loader engines: load_bias, load_weight and load_image.
- Sits between the loaders' O_maxi_* / O_stable_rready interfaces and the single external AXI read master.
- Grants one burst at a time, in round-robin order, and holds the grant until every R beat of that burst has been delivered.
- Returns read data to the granted loader only.

Parameters:
- C_REQ_NUM, 3, number of requesting loaders; index 0 = bias, 1 = weight, 2 = image.
- C_M_AXI_LEN_WIDTH, 32, width of each arlen field.
- C_M_AXI_ADDR_WIDTH, 32, width of each araddr field.
- C_M_AXI_DATA_WIDTH, 128, width of rdata.

Ports:
- I_clk  input  1  single clock.
- I_rst_n  input  1  reset; asynchronous, active-low.
- I_arvalid  input  C_REQ_NUM  per-loader AR request.
- I_araddr  input  C_REQ_NUM*C_M_AXI_ADDR_WIDTH  packed addresses; loader i occupies slice i.
- I_arlen  input  C_REQ_NUM*C_M_AXI_LEN_WIDTH  packed burst lengths; beats = arlen+1.
- O_arready  output  C_REQ_NUM  per-loader AR accept.
- I_rready  input  C_REQ_NUM  per-loader rready.
- O_rvalid  output  C_REQ_NUM  per-loader rvalid.
- O_rdata  output  C_M_AXI_DATA_WIDTH  read data, broadcast to all loaders.
- O_gnt  output  C_REQ_NUM  one-hot owner of the current burst; all zero in IDLE.
- O_busy  output  1  high whenever the FSM is not in IDLE.
- O_maxi_arvalid  output  1  to the AXI master.
- O_maxi_araddr  output  C_M_AXI_ADDR_WIDTH  to the AXI master.
- O_maxi_arlen  output  C_M_AXI_LEN_WIDTH  to the AXI master.
- I_maxi_arready  input  1  from the AXI master.
- O_maxi_rready  output  1  to the AXI master.
- I_maxi_rvalid  input  1  from the AXI master.
- I_maxi_rdata  input  C_M_AXI_DATA_WIDTH  from the AXI master.

Behaviour:
- Reset (asynchronous, I_rst_n=0):
  - state=IDLE, round-robin pointer=0, beat counter=0.
  - O_gnt=0, O_busy=0, O_maxi_arvalid=0, O_maxi_araddr=0, O_maxi_arlen=0.
  - O_arready=0, O_rvalid=0, O_maxi_rready=0.
  - A reset in the middle of a burst abandons the burst; no completion is signalled.
- FSM states: IDLE -> AR -> RDATA -> IDLE.
- IDLE:
  - Winner = first i with I_arvalid[i]=1, searching from the pointer upward and wrapping modulo C_REQ_NUM.
  - O_arready[winner]=1 combinationally in that same cycle; this is the loader-side AR handshake.
  - On that clock edge: latch the winner's araddr/arlen; set O_gnt to the winner (one-hot); set pointer = (winner+1) mod C_REQ_NUM; go to AR.
  - No request present: stay in IDLE.
- AR:
  - O_maxi_arvalid=1; araddr/arlen are driven from the latched registers and held stable until I_maxi_arready=1.
  - Edge with arvalid&&arready: O_maxi_arvalid deasserts in the next cycle; counter cleared; go to RDATA.
  - Latency: loader handshake at cycle t -> O_maxi_arvalid high at t+1.
- RDATA:
  - O_maxi_rready = I_rready[gnt].
  - O_rvalid[i] = I_maxi_rvalid && O_gnt[i].
  - O_rdata = I_maxi_rdata, combinational pass-through with no added latency.
  - Counter increments on each beat with I_maxi_rvalid && O_maxi_rready.
  - The beat on which counter==latched arlen is the last beat; go to IDLE on that edge and clear O_gnt.
- Outside RDATA: O_maxi_rready=0 and O_rvalid=0. Stray I_maxi_rvalid is ignored and never forwarded.
- O_arready is 0 in the AR and RDATA states. A requester whose arvalid is denied must keep it high; its request is not lost.
- arlen=0 is a single-beat burst: RDATA lasts exactly one accepted beat.
- Counter width is C_M_AXI_LEN_WIDTH; comparison is equality with no wrap. arlen=2^W-1 is supported.
- Back-to-back bursts: one IDLE cycle minimum between the last R beat and the next arbitration.
- Fairness: with all requesters continuously asserting, grants go 0,1,2,0,...; no requester waits longer than C_REQ_NUM-1 bursts.

Decomposition:
- Shared header/package: FSM state localparams (IDLE=2'd0, AR=2'd1, RDATA=2'd2) and a log2 function for pointer width, reused by the other loaders' controllers.
- One sub-module, rr_pick: combinational round-robin select.
  - Inputs: request vector and pointer.
  - Outputs: one-hot winner, winner index, any_req.
- FSM, latches and counter stay in the top module.

Test Plan:
- Single request: I_arvalid=001, araddr=0x1000, arlen=3; I_maxi_arready high after 2 cycles; 4 rvalid beats -> O_maxi_araddr=0x1000, O_maxi_arlen=3, O_gnt=001 throughout, O_rvalid[0] on 4 beats only, back to IDLE after beat 4.
- All three requesting continuously with arlen=0 -> grant order 001,010,100,001; O_arready pulses exactly once per grant.
- Backpressure: loader 1 granted, I_rready[1] toggles 1,0,1,0 over 4 beats with arlen=1 -> O_maxi_rready mirrors it; counter reaches 1 only after 2 accepted beats.
- I_maxi_rvalid asserted while in IDLE/AR with data 0xDEAD -> all O_rvalid=0 and O_maxi_rready=0.
- I_rst_n pulled low mid-RDATA (beat 2 of 8) -> all outputs 0 immediately, pointer=0; next request from loader 2 is granted normally.
- arlen=0xFFFF_FFFF: check that the counter compare has no wrap; at minimum, that the latched arlen is driven unmodified on O_maxi_arlen.
